// File: rtl/paddle_conditioner.sv
// Paddle position conditioner: block-averages XADC samples, clamps to the playfield,
// and slews the paddle toward the target once per frame. Optional macro: PAD_DEADBAND_EN.
module paddle_conditioner #(
  parameter int         AVG_LOG2  = 2,
  parameter logic [9:0] PAD_MAX   = 10'd520,
  parameter logic [9:0] PAD_RESET = 10'd260,
  parameter logic [9:0] MAX_STEP  = 10'd8,
  parameter logic [9:0] DEADBAND  = 10'd3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_adc_sample,
  input  logic        i_adc_valid,
  input  logic        i_frame,
  output logic [9:0]  o_pad,
  output logic        o_pad_valid,
  output logic        o_settled
);

  localparam int ACC_W = 10 + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;
`ifdef PAD_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  typedef enum logic {WAIT_FIRST = 1'b0, TRACK = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [ACC_W-1:0]    r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [9:0]          r_target, r_pad;
  logic                r_pad_valid, r_settled;

  logic [9:0]       w_s, w_avg, w_cand, w_cand_dist, w_pad_gap, w_step;
  logic [9:0]       w_target_nxt, w_pad_nxt;
  logic [ACC_W-1:0] w_sum;
  logic             w_blk_done, w_settled_nxt;
  logic             w_unused_lsb;

  // Negative-flagged conversions count as zero-valued samples, not dropped ones.
  assign w_s          = i_adc_sample[15] ? 10'd0 : i_adc_sample[14:5];
  assign w_unused_lsb = ^i_adc_sample[4:0];

  assign w_sum      = r_acc + ACC_W'(w_s);
  assign w_blk_done = i_adc_valid && (r_cnt == CNT_LAST);
  assign w_avg      = w_sum[ACC_W-1:AVG_LOG2];
  assign w_cand     = (w_avg > PAD_MAX) ? PAD_MAX : w_avg;

  assign w_cand_dist = (w_cand >= r_target) ? (w_cand - r_target) : (r_target - w_cand);
  assign w_pad_gap   = (r_target >= r_pad) ? (r_target - r_pad) : (r_pad - r_target);
  assign w_step      = (w_pad_gap > MAX_STEP) ? MAX_STEP : w_pad_gap;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_adc_valid) begin
      if (w_blk_done) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + AVG_LOG2'(1);
      end
    end
  end

  // Slew always chases the pre-edge target, so a block completing on a frame
  // cycle only takes effect at the following frame.
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_pad_nxt    = r_pad;
    case (r_state)
      WAIT_FIRST: begin
        if (w_blk_done) begin
          w_target_nxt = w_cand;
          w_state_nxt  = TRACK;
        end
      end
      TRACK: begin
        if (w_blk_done && (!DB_EN || (w_cand_dist >= DEADBAND)))
          w_target_nxt = w_cand;
        if (i_frame)
          w_pad_nxt = (r_target >= r_pad) ? (r_pad + w_step) : (r_pad - w_step);
      end
      default: w_state_nxt = WAIT_FIRST;
    endcase
  end

  assign w_settled_nxt = (w_state_nxt == TRACK) && (w_pad_nxt == w_target_nxt);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= WAIT_FIRST;
      r_target    <= PAD_RESET;
      r_pad       <= PAD_RESET;
      r_pad_valid <= 1'b0;
      r_settled   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_target    <= w_target_nxt;
      r_pad       <= w_pad_nxt;
      r_pad_valid <= (w_state_nxt == TRACK);
      r_settled   <= w_settled_nxt;
    end
  end

  assign o_pad       = r_pad;
  assign o_pad_valid = r_pad_valid;
  assign o_settled   = r_settled;

endmodule
